// File: rtl/mem_pkg.sv
// mem_pkg: shared codes and helpers for the memory-access stage.
// Op-field slicing, kind/exception codes and FSM state type.
package mem_pkg;

  localparam int OP_W = 5;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;
  localparam logic [1:0] MEM_ATOM  = 2'b11;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_ADEL   = 2'b01;
  localparam logic [1:0] EXC_ADES   = 2'b10;
  localparam logic [1:0] EXC_BUSERR = 2'b11;

  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } ls_state_e;

  function automatic logic [1:0] op_kind(input logic [OP_W-1:0] op);
    return op[4:3];
  endfunction

  function automatic logic op_sgn(input logic [OP_W-1:0] op);
    return op[2];
  endfunction

  function automatic logic [1:0] op_size(input logic [OP_W-1:0] op);
    return op[1:0];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and
// extraction plus sign/zero extension for loads.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                   i_size,
  input  logic                         i_sgn,
  input  logic [$clog2(DATA_W/8)-1:0]  i_off,
  input  logic [DATA_W-1:0]            i_sdata,
  input  logic [DATA_W-1:0]            i_rdata,
  output logic [DATA_W/8-1:0]          o_sel,
  output logic [DATA_W-1:0]            o_wdata,
  output logic [DATA_W-1:0]            o_ldata
);

  localparam int NB = DATA_W/8;

  int                w_nb;
  logic [DATA_W-1:0] w_shf;
  logic              w_sbit;

  // Lane masks, replicated store data and extended load data.
  always_comb begin
    w_nb   = 1 << i_size;
    if (w_nb > NB) w_nb = NB;
    w_shf  = i_rdata >> {i_off, 3'b000};
    w_sbit = i_sgn & w_shf[8*w_nb-1];
    for (int i = 0; i < NB; i++) begin
      o_sel[i] = (i >= int'(i_off)) &&
                 (i < int'(i_off) + w_nb);
      o_wdata[8*i +: 8] = i_sdata[8*(i & (w_nb-1)) +: 8];
      o_ldata[8*i +: 8] = (i < w_nb) ? w_shf[8*i +: 8]
                                     : {8{w_sbit}};
    end
  end

endmodule

// File: rtl/mem_ls.sv
// mem_ls: MEM stage with load/store/LL/SC over a req/ack bus,
// stall generation, bus timeout and LLbit tracking.
module mem_ls
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [4:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_sdata_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic                  cp0_reg_we_i,
  input  logic [REG_ADDR_W-1:0] cp0_reg_write_addr_i,
  input  logic [DATA_W-1:0]     cp0_reg_data_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  cp0_reg_we_o,
  output logic [REG_ADDR_W-1:0] cp0_reg_write_addr_o,
  output logic [DATA_W-1:0]     cp0_reg_data_o,
  output logic                  stallreq_o,
  output logic [1:0]            excpt_o,
  output logic [ADDR_W-1:0]     bad_addr_o,
  output logic                  llbit_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_sel_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int NB    = DATA_W/8;
  localparam int OFF_W = $clog2(NB);

  ls_state_e         r_state, w_nstate;
  logic [31:0]       r_cnt;
  logic              r_llbit;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [NB-1:0]     r_sel;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_kind, w_size;
  logic              w_sgn;
  logic [OFF_W-1:0]  w_off, w_amask;
  logic              w_rd, w_wr, w_ll, w_sc;
  logic              w_illegal, w_scfail, w_need;
  logic [ADDR_W-1:0] w_waddr;
  logic [NB-1:0]     w_sel;
  logic [DATA_W-1:0] w_wdata, w_ldata;
  logic              w_req, w_stall, w_done, w_berr, w_tmo;

  // Op decode, legality and whether the bus is needed.
  always_comb begin
    w_kind = op_kind(mem_op_i);
    w_sgn  = op_sgn(mem_op_i);
    w_size = (w_kind == MEM_ATOM) ? SZ_WORD : op_size(mem_op_i);
    w_off  = mem_addr_i[OFF_W-1:0];
    for (int i = 0; i < OFF_W; i++)
      w_amask[i] = (i < int'(w_size));
    w_ll = (w_kind == MEM_ATOM) && !w_sgn;
    w_sc = (w_kind == MEM_ATOM) && w_sgn;
    w_rd = (w_kind == MEM_LOAD) || w_ll;
    w_wr = (w_kind == MEM_STORE) || w_sc;
    w_illegal = (w_rd || w_wr) &&
                ((int'(w_size) > OFF_W) || (|(w_off & w_amask)));
    w_scfail = w_sc && !r_llbit && !w_illegal;
    w_need   = (w_rd || w_wr) && !w_illegal && !w_scfail;
    w_waddr  = {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    w_tmo    = (TIMEOUT_CYC > 0) &&
               (r_cnt == 32'(TIMEOUT_CYC - 1));
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_size  (w_size),
    .i_sgn   (w_sgn),
    .i_off   (w_off),
    .i_sdata (mem_sdata_i),
    .i_rdata (mem_rdata_i),
    .o_sel   (w_sel),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  // Next state, request, stall, completion and bus error.
  always_comb begin
    w_nstate = r_state;
    w_req    = 1'b0;
    w_stall  = 1'b0;
    w_done   = 1'b0;
    w_berr   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_need) begin
          w_req = 1'b1;
          if (mem_ack_i) begin
            w_done = 1'b1;
          end else begin
            w_stall  = 1'b1;
            w_nstate = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (mem_ack_i) begin
          w_done   = 1'b1;
          w_nstate = ST_IDLE;
        end else if (flush_i) begin
          w_nstate = ST_DRAIN;
        end else if (w_tmo) begin
          w_berr   = 1'b1;
          w_nstate = ST_DRAIN;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_req = 1'b1;
        if (mem_ack_i) w_nstate = ST_IDLE;
        if (w_need) w_stall = 1'b1;
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  // Writeback, exception and bus outputs; all zero in reset.
  always_comb begin
    wdata_o              = wdata_i;
    wd_o                 = wd_i;
    wreg_o               = wreg_i;
    hi_o                 = hi_i;
    lo_o                 = lo_i;
    whilo_o              = whilo_i;
    cp0_reg_we_o         = cp0_reg_we_i;
    cp0_reg_write_addr_o = cp0_reg_write_addr_i;
    cp0_reg_data_o       = cp0_reg_data_i;
    stallreq_o           = w_stall;
    excpt_o              = EXC_NONE;
    bad_addr_o           = '0;
    llbit_o              = r_llbit;
    mem_req_o            = w_req;
    if (r_state == ST_IDLE) begin
      mem_we_o    = w_wr;
      mem_addr_o  = w_waddr;
      mem_sel_o   = w_sel;
      mem_wdata_o = w_wdata;
    end else begin
      mem_we_o    = r_we;
      mem_addr_o  = r_addr;
      mem_sel_o   = r_sel;
      mem_wdata_o = r_wdata;
    end
    if (w_illegal || w_berr) begin
      wreg_o       = 1'b0;
      whilo_o      = 1'b0;
      cp0_reg_we_o = 1'b0;
      bad_addr_o   = mem_addr_i;
      excpt_o      = w_berr ? EXC_BUSERR :
                     (w_rd ? EXC_ADEL : EXC_ADES);
    end else if (w_scfail) begin
      wdata_o = '0;
    end else if (w_done) begin
      if (w_rd)      wdata_o = w_ldata;
      else if (w_sc) wdata_o = DATA_W'(1);
    end
    if (rst) begin
      wdata_o              = '0;
      wd_o                 = '0;
      wreg_o               = 1'b0;
      hi_o                 = '0;
      lo_o                 = '0;
      whilo_o              = 1'b0;
      cp0_reg_we_o         = 1'b0;
      cp0_reg_write_addr_o = '0;
      cp0_reg_data_o       = '0;
      stallreq_o           = 1'b0;
      excpt_o              = EXC_NONE;
      bad_addr_o           = '0;
      llbit_o              = 1'b0;
      mem_req_o            = 1'b0;
      mem_we_o             = 1'b0;
      mem_addr_o           = '0;
      mem_sel_o            = '0;
      mem_wdata_o          = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nstate;
  end

  // Cycles spent in WAIT; cleared whenever WAIT is left.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (r_state == ST_WAIT && w_nstate == ST_WAIT)
      r_cnt <= r_cnt + 32'd1;
    else
      r_cnt <= '0;
  end

  // LLbit: flush beats an LL completing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i)    r_llbit <= 1'b0;
    else if (w_done && w_ll) r_llbit <= 1'b1;
    else if (w_done && w_sc) r_llbit <= 1'b0;
  end

  // Keep the issued request so DRAIN can hold it after upstream moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && w_need) begin
      r_addr  <= w_waddr;
      r_we    <= w_wr;
      r_sel   <= w_sel;
      r_wdata <= w_wdata;
    end
  end

endmodule

// File: tb/tb_mem_ls.sv
// tb_mem_ls: directed and randomized checks of mem_ls
// against a byte-level reference model.
module tb_mem_ls;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [4:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_sdata_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i, lo_i;
  logic        whilo_i, cp0_reg_we_i;
  logic [4:0]  cp0_reg_write_addr_i;
  logic [31:0] cp0_reg_data_i;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] hi_o, lo_o;
  logic        whilo_o, cp0_reg_we_o;
  logic [4:0]  cp0_reg_write_addr_o;
  logic [31:0] cp0_reg_data_o;
  logic        stallreq_o;
  logic [1:0]  excpt_o;
  logic [31:0] bad_addr_o;
  logic        llbit_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ls #(
    .DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i),
    .wdata_i(wdata_i), .wdata_o(wdata_o),
    .wd_i(wd_i), .wd_o(wd_o),
    .wreg_i(wreg_i), .wreg_o(wreg_o),
    .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o),
    .whilo_i(whilo_i), .whilo_o(whilo_o),
    .cp0_reg_we_i(cp0_reg_we_i), .cp0_reg_we_o(cp0_reg_we_o),
    .cp0_reg_write_addr_i(cp0_reg_write_addr_i),
    .cp0_reg_write_addr_o(cp0_reg_write_addr_o),
    .cp0_reg_data_i(cp0_reg_data_i),
    .cp0_reg_data_o(cp0_reg_data_o),
    .stallreq_o(stallreq_o), .excpt_o(excpt_o),
    .bad_addr_o(bad_addr_o), .llbit_o(llbit_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    flush_i = 0; mem_op_i = 5'b00000; mem_ack_i = 0;
    mem_addr_i = 0; mem_sdata_i = 0; mem_rdata_i = 0;
    wdata_i = 32'hCAFE0001; wd_i = 5'd3; wreg_i = 1;
    hi_i = 32'h1111; lo_i = 32'h2222; whilo_i = 0;
    cp0_reg_we_i = 0; cp0_reg_write_addr_i = 0;
    cp0_reg_data_i = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    mem_op_i = 5'b01010; mem_addr_i = 32'h100;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (wdata_o !== 0 || wreg_o !== 0 || mem_req_o !== 0 ||
        stallreq_o !== 0 || llbit_o !== 0 || hi_o !== 0) begin
      n_fail++;
      $display("FAIL reset_outs wdata=%h wreg=%b req=%b stall=%b ll=%b hi=%h need all 0",
               wdata_o, wreg_o, mem_req_o, stallreq_o, llbit_o, hi_o);
    end
    tick();
    rst = 0;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 0 || llbit_o !== 0 || stallreq_o !== 0) begin
      n_fail++;
      $display("FAIL post_reset req=%b ll=%b stall=%b need 0",
               mem_req_o, llbit_o, stallreq_o);
    end
    tick();
  endtask

  task automatic test_passthru();
    set_idle();
    wdata_i = 32'h12345678; wd_i = 5; whilo_i = 1;
    hi_i = 32'hA5A5A5A5; cp0_reg_we_i = 1;
    cp0_reg_write_addr_i = 5'd12; cp0_reg_data_i = 32'h77;
    @(negedge clk);
    n_checks++;
    if (wdata_o !== 32'h12345678 || wd_o !== 5 || whilo_o !== 1 ||
        hi_o !== 32'hA5A5A5A5 || lo_o !== 32'h2222 ||
        cp0_reg_we_o !== 1 || cp0_reg_write_addr_o !== 5'd12 ||
        cp0_reg_data_o !== 32'h77 || wreg_o !== 1) begin
      n_fail++;
      $display("FAIL passthru wdata=%h wd=%0d whilo=%b hi=%h cp0=%b/%0d/%h",
               wdata_o, wd_o, whilo_o, hi_o, cp0_reg_we_o,
               cp0_reg_write_addr_o, cp0_reg_data_o);
    end
    n_checks++;
    if (mem_req_o !== 0 || stallreq_o !== 0 || excpt_o !== 0) begin
      n_fail++;
      $display("FAIL passthru_bus req=%b stall=%b exc=%b need 0",
               mem_req_o, stallreq_o, excpt_o);
    end
    tick();
  endtask

  task automatic test_lb();
    set_idle();
    mem_op_i = 5'b01100; mem_addr_i = 32'h1003;
    mem_rdata_i = 32'h80FFFFFF; mem_ack_i = 1;
    @(negedge clk);
    n_checks++;
    if (mem_sel_o !== 4'b1000 || wdata_o !== 32'hFFFFFF80 ||
        stallreq_o !== 0 || mem_req_o !== 1 ||
        mem_addr_o !== 32'h1000) begin
      n_fail++;
      $display("FAIL lb_sext sel=%b wdata=%h stall=%b req=%b addr=%h need 1000/FFFFFF80/0/1/1000",
               mem_sel_o, wdata_o, stallreq_o, mem_req_o, mem_addr_o);
    end
    tick();
  endtask

  task automatic test_sh_wait();
    int  stalls = 0;
    bit  done = 0;
    set_idle();
    mem_op_i = 5'b10001; mem_addr_i = 32'h2002;
    mem_sdata_i = 32'h0000ABCD;
    for (int c = 0; c < 10 && !done; c++) begin
      mem_ack_i = (c == 3);
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (mem_sel_o !== 4'b1100 || mem_wdata_o !== 32'hABCDABCD ||
            mem_we_o !== 1 || mem_req_o !== 1) begin
          n_fail++;
          $display("FAIL sh_steer sel=%b wdata=%h we=%b req=%b need 1100/ABCDABCD/1/1",
                   mem_sel_o, mem_wdata_o, mem_we_o, mem_req_o);
        end
      end
      if (stallreq_o) stalls++;
      else done = 1;
      tick();
    end
    set_idle();
    n_checks++;
    if (stalls != 3 || !done) begin
      n_fail++;
      $display("FAIL sh_stall_cycles got=%0d need 3 done=%b",
               stalls, done);
    end
  endtask

  task automatic test_misaligned();
    set_idle();
    mem_op_i = 5'b01010; mem_addr_i = 32'h3001; wreg_i = 1;
    @(negedge clk);
    n_checks++;
    if (excpt_o !== 2'b01 || bad_addr_o !== 32'h3001 ||
        wreg_o !== 0 || mem_req_o !== 0 || stallreq_o !== 0) begin
      n_fail++;
      $display("FAIL lw_misalign exc=%b bad=%h wreg=%b req=%b need 01/3001/0/0",
               excpt_o, bad_addr_o, wreg_o, mem_req_o);
    end
    tick();
  endtask

  task automatic test_llsc();
    set_idle();
    mem_op_i = 5'b11000; mem_addr_i = 32'h40;
    mem_rdata_i = 32'hDEADBEEF; mem_ack_i = 1;
    @(negedge clk);
    n_checks++;
    if (wdata_o !== 32'hDEADBEEF || mem_sel_o !== 4'hF ||
        mem_req_o !== 1 || mem_we_o !== 0) begin
      n_fail++;
      $display("FAIL ll_load wdata=%h sel=%b req=%b we=%b",
               wdata_o, mem_sel_o, mem_req_o, mem_we_o);
    end
    tick();
    mem_op_i = 5'b11100; mem_sdata_i = 32'h55;
    @(negedge clk);
    n_checks++;
    if (llbit_o !== 1) begin
      n_fail++;
      $display("FAIL ll_set llbit=%b need 1", llbit_o);
    end
    n_checks++;
    if (mem_req_o !== 1 || mem_we_o !== 1 || wdata_o !== 1 ||
        mem_wdata_o !== 32'h55) begin
      n_fail++;
      $display("FAIL sc_ok req=%b we=%b wdata=%h bus=%h need 1/1/1/55",
               mem_req_o, mem_we_o, wdata_o, mem_wdata_o);
    end
    tick();
    mem_ack_i = 0;
    @(negedge clk);
    n_checks++;
    if (llbit_o !== 0 || mem_req_o !== 0 || wdata_o !== 0 ||
        stallreq_o !== 0 || wreg_o !== 1) begin
      n_fail++;
      $display("FAIL sc_fail ll=%b req=%b wdata=%h stall=%b wreg=%b need 0/0/0/0/1",
               llbit_o, mem_req_o, wdata_o, stallreq_o, wreg_o);
    end
    tick();
    set_idle();
  endtask

  task automatic test_timeout();
    int hit = -1;
    set_idle();
    mem_op_i = 5'b01010; mem_addr_i = 32'h100;
    for (int c = 0; c < 12 && hit < 0; c++) begin
      @(negedge clk);
      if (excpt_o == 2'b11) begin
        hit = c;
        n_checks++;
        if (stallreq_o !== 0 || wreg_o !== 0 ||
            bad_addr_o !== 32'h100) begin
          n_fail++;
          $display("FAIL buserr_fields stall=%b wreg=%b bad=%h",
                   stallreq_o, wreg_o, bad_addr_o);
        end
      end
      tick();
    end
    n_checks++;
    if (hit != 4) begin
      n_fail++;
      $display("FAIL buserr_cycle got=%0d need 4", hit);
    end
    mem_op_i = 5'b00000; mem_addr_i = 32'h0;
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1 || mem_addr_o !== 32'h100 ||
        stallreq_o !== 0 || excpt_o !== 0) begin
      n_fail++;
      $display("FAIL drain_hold req=%b addr=%h stall=%b exc=%b",
               mem_req_o, mem_addr_o, stallreq_o, excpt_o);
    end
    tick();
    mem_op_i = 5'b01010; mem_addr_i = 32'h300;
    mem_rdata_i = 32'h0BADF00D;
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1 || mem_addr_o !== 32'h100 ||
        stallreq_o !== 1) begin
      n_fail++;
      $display("FAIL drain_new req=%b addr=%h stall=%b need 1/100/1",
               mem_req_o, mem_addr_o, stallreq_o);
    end
    tick();
    mem_ack_i = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1 || mem_addr_o !== 32'h300 ||
        stallreq_o !== 0 || wdata_o !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL after_drain req=%b addr=%h stall=%b wdata=%h",
               mem_req_o, mem_addr_o, stallreq_o, wdata_o);
    end
    tick();
    set_idle();
  endtask

  task automatic test_flush();
    set_idle();
    mem_op_i = 5'b11000; mem_addr_i = 32'h80; mem_ack_i = 1;
    tick();
    mem_ack_i = 0;
    mem_op_i = 5'b01010; mem_addr_i = 32'h200;
    tick();
    flush_i = 1;
    @(negedge clk);
    n_checks++;
    if (stallreq_o !== 0 || llbit_o !== 1) begin
      n_fail++;
      $display("FAIL flush_wait stall=%b ll=%b need 0/1",
               stallreq_o, llbit_o);
    end
    tick();
    flush_i = 0; mem_op_i = 5'b00000;
    @(negedge clk);
    n_checks++;
    if (llbit_o !== 0 || mem_req_o !== 1 ||
        mem_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL flush_drain ll=%b req=%b addr=%h need 0/1/200",
               llbit_o, mem_req_o, mem_addr_o);
    end
    mem_ack_i = 1;
    tick();
    mem_ack_i = 0;
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 0) begin
      n_fail++;
      $display("FAIL flush_idle req=%b need 0", mem_req_o);
    end
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int          kind, sz, nb, off;
      bit          sg, bad;
      logic [63:0] v, m;
      logic [31:0] e_wd, e_data;
      logic [3:0]  e_sel;
      set_idle();
      kind = $urandom_range(0, 2);
      sg   = 1'($urandom_range(0, 1));
      sz   = $urandom_range(0, 3);
      mem_op_i    = {2'(kind), sg, 2'(sz)};
      mem_addr_i  = $urandom;
      mem_sdata_i = $urandom;
      mem_rdata_i = $urandom;
      wdata_i     = $urandom;
      mem_ack_i   = 1;
      nb  = 1 << sz;
      off = mem_addr_i % 4;
      bad = (kind != 0) && (sz > 2 || (mem_addr_i % nb) != 0);
      e_sel = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++)
        e_wd[8*i +: 8] = 8'(mem_sdata_i >> (8 * (i % nb)));
      m = (64'd1 << (8 * nb)) - 1;
      v = (64'(mem_rdata_i) >> (8 * off)) & m;
      if (sg && v[8*nb-1]) v = v | ~m;
      e_data = (kind == 1) ? v[31:0] : wdata_i;
      @(negedge clk);
      n_checks++;
      if (bad) begin
        if (excpt_o !== ((kind == 1) ? 2'b01 : 2'b10) ||
            bad_addr_o !== mem_addr_i || mem_req_o !== 0 ||
            wreg_o !== 0) begin
          n_fail++;
          $display("FAIL rnd_illegal it=%0d op=%b addr=%h exc=%b bad=%h req=%b wreg=%b",
                   it, mem_op_i, mem_addr_i, excpt_o, bad_addr_o,
                   mem_req_o, wreg_o);
        end
      end else if (kind == 0) begin
        if (mem_req_o !== 0 || wdata_o !== wdata_i ||
            excpt_o !== 0) begin
          n_fail++;
          $display("FAIL rnd_none it=%0d req=%b wdata=%h need %h",
                   it, mem_req_o, wdata_o, wdata_i);
        end
      end else begin
        if (mem_req_o !== 1 || stallreq_o !== 0 ||
            mem_sel_o !== e_sel || wdata_o !== e_data ||
            mem_we_o !== (kind == 2) || excpt_o !== 0 ||
            mem_addr_o !== {mem_addr_i[31:2], 2'b00} ||
            (kind == 2 && mem_wdata_o !== e_wd)) begin
          n_fail++;
          $display("FAIL rnd_access it=%0d op=%b addr=%h sel=%b/%b wdata=%h/%h bus=%h/%h req=%b",
                   it, mem_op_i, mem_addr_i, mem_sel_o, e_sel,
                   wdata_o, e_data, mem_wdata_o, e_wd, mem_req_o);
        end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_lb();
    test_sh_wait();
    test_misaligned();
    test_llsc();
    test_timeout();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ls.md
# mem_ls

Parametrised memory-access stage between the EX/MEM and MEM/WB pipeline registers. It supersedes the pure pass-through MEM stage. It forwards register-file, HI/LO and CP0 write fields. It also executes loads and stores, including LL/SC, over a req/ack data bus with byte-lane steering and sign/zero extension. Stall requests, misalignment and bus-timeout exceptions, and the LLbit flag are generated here.

## Interface
Parameters:
- DATA_W, 32, data/register width; multiple of 8, power of two (32 or 64)
- ADDR_W, 32, byte address width
- REG_ADDR_W, 5, register-file address width
- TIMEOUT_CYC, 0, maximum cycles in WAIT before bus error; 0 disables the timeout

Ports (all outputs are forced to 0 while rst=1):
- clk  in  1  clock; single clock domain, rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush from ctrl
- mem_op_i  in  5  {kind[1:0], sgn, size[1:0]}; encoding in mem_pkg
- mem_addr_i  in  ADDR_W  effective byte address
- mem_sdata_i  in  DATA_W  store data, right-aligned
- wdata_i/wdata_o  in/out  DATA_W  register writeback data
- wd_i/wd_o  in/out  REG_ADDR_W  destination register
- wreg_i/wreg_o  in/out  1  register write enable
- hi_i, lo_i / hi_o, lo_o  in/out  DATA_W  HI/LO values
- whilo_i/whilo_o  in/out  1  HI/LO write enable
- cp0_reg_we_i/_o, cp0_reg_write_addr_i/_o, cp0_reg_data_i/_o  in/out  1/REG_ADDR_W/DATA_W  CP0 write fields
- stallreq_o  out  1  hold EX/MEM and earlier stages
- excpt_o  out  2  00 none, 01 ADEL, 10 ADES, 11 BUSERR
- bad_addr_o  out  ADDR_W  faulting address; 0 when excpt_o=00
- llbit_o  out  1  current LLbit
- mem_req_o, mem_we_o  out  1  bus request, write
- mem_addr_o  out  ADDR_W  word-aligned address
- mem_sel_o  out  DATA_W/8  byte-lane enables
- mem_wdata_o  out  DATA_W  lane-replicated store data
- mem_rdata_i  in  DATA_W  read data, valid with ack
- mem_ack_i  in  1  transfer complete

## Operation
- Decoding of kind:
  - 00 none: all *_o fields equal the corresponding *_i fields; no bus activity.
  - 01 load, 10 store.
  - 11 atomic: sgn=0 is LL, sgn=1 is SC; size is forced to a full 32-bit word.
- Legality: size > log2(DATA_W/8), or mem_addr_i not aligned to 2^size, makes the access illegal.
  - Illegal access: no request is issued. excpt_o = ADEL (load/LL) or ADES (store/SC), bad_addr_o = mem_addr_i.
  - wreg_o, whilo_o and cp0_reg_we_o are forced to 0.
- Store steering:
  - mem_sel_o = ((1<<2^size)-1) << offset, where offset = mem_addr_i[log2(DATA_W/8)-1:0].
  - mem_wdata_o = low 2^size bytes of mem_sdata_i replicated across all lanes.
  - mem_addr_o = mem_addr_i with the offset bits cleared.
- Load extract: take 2^size bytes of mem_rdata_i starting at offset; sign-extend if sgn=1, else zero-extend. The result drives wdata_o.
- LL: performs a word load; on completion the LLbit is set at the next clock edge.
- SC with LLbit=0: no bus access; wdata_o=0, wreg_o=wreg_i; completes immediately.
- SC with LLbit=1: performs a word store; on completion wdata_o=1 and the LLbit is cleared.
- LLbit is cleared by rst or flush_i. A flush takes priority over an LL set in the same cycle.

## Timing
- FSM states: IDLE, WAIT, DRAIN. Reset puts the FSM in IDLE with the timeout counter at 0 and LLbit at 0.
- IDLE with a legal access: mem_req_o=1 combinationally.
  - mem_ack_i in the same cycle: the access completes with zero wait and stallreq_o=0.
  - Otherwise stallreq_o=1 and the next state is WAIT.
- WAIT:
  - mem_req_o stays high; addr/we/sel/wdata are held stable by the stalled upstream register.
  - The timeout counter increments every cycle.
  - On ack: the access completes, stallreq_o=0, next state IDLE, counter cleared.
- Timeout (TIMEOUT_CYC>0): reached when the counter equals TIMEOUT_CYC-1 and there is no ack.
  - excpt_o=BUSERR, bad_addr_o=mem_addr_i, stallreq_o=0; writes are suppressed as for an illegal access.
  - Next state DRAIN.
- flush_i in WAIT: stallreq_o=0, next state DRAIN.
- DRAIN:
  - mem_req_o stays high with the held request until mem_ack_i; the read data is discarded; then IDLE.
  - A new legal access arriving during DRAIN gets stallreq_o=1 and no request until DRAIN exits.
- An ack that arrives in the same cycle as the timeout counts as completion; no BUSERR is raised.

## Structure
- Shared package mem_pkg holds:
  - the kind codes (MEM_NONE/LOAD/STORE/ATOM);
  - the excpt_o codes;
  - the FSM state typedef;
  - the field slices of mem_op_i.
- Sub-module mem_lane_align (combinational, parameter DATA_W) generates mem_sel_o and mem_wdata_o and performs load extraction/extension. The FSM, timeout counter and LLbit stay in mem_ls.

## Test plan
- Pass-through: kind=00 with wdata_i=0x12345678, wd_i=5, whilo_i=1 -> outputs identical, mem_req_o=0, stallreq_o=0.
- LB sign-extend: addr=0x1003, rdata=0x80FFFFFF, ack in the same cycle -> mem_sel_o=4'b1000, wdata_o=0xFFFFFF80, no stall.
- SH with wait: addr=0x2002, sdata=0xABCD, ack after 3 cycles -> sel=4'b1100, wdata=0xABCDABCD, stallreq_o high for exactly 3 cycles.
- Misaligned LW at addr=0x3001 -> excpt_o=01, bad_addr_o=0x3001, wreg_o=0, no request.
- LL at 0x40 then SC at 0x40 -> SC stores and wdata_o=1, LLbit cleared; a second SC -> no request, wdata_o=0.
- TIMEOUT_CYC=4, ack withheld -> BUSERR on the 4th WAIT cycle, DRAIN holds req until ack; flush_i during WAIT -> DRAIN, LLbit cleared.
